// File: rtl/ext_amp_cat_tx.sv
// rtl/ext_amp_cat_tx.sv - amplifier band-control sender: freq -> "F<A|B><digits>;" over UART
module ext_amp_cat_tx #(
    parameter int CLKFREQ        = 76800000,
    parameter int BAUDRATE       = 9600,
    parameter int NDIGITS        = 11,
    parameter int STOP_BITS      = 1,
    parameter int TXD_INVERT     = 1,
    parameter int SETTLE_CYCLES  = 76800,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] freq,
    input  logic        vfo_sel,
    input  logic        ptt,
    output logic        uart_txd,
    output logic        busy,
    output logic        sent
);

    localparam int DIV    = CLKFREQ / BAUDRATE;
    localparam int NBYTES = NDIGITS + 3;
    localparam int NBITS  = 9 + STOP_BITS;
    localparam int BAUD_W = $clog2(DIV);
    localparam int BIT_W  = $clog2(NBITS);
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int REF_W  = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

    localparam logic              INV       = (TXD_INVERT != 0);
    localparam logic [31:0]       FREQ_MAX  = 32'd99999999;
    localparam logic [SET_W-1:0]  SET_MAX   = SET_W'(SETTLE_CYCLES);
    localparam logic [REF_W-1:0]  REF_MAX   = REF_W'(REFRESH_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [BYTE_W-1:0] DPOS_TOP  = BYTE_W'(NDIGITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CONV, ST_TX} state_t;

    state_t              state, state_nx;
    logic [31:0]         last_sent;
    logic [31:0]         freq_prev;
    logic [31:0]         freq_bin;
    logic [31:0]         dd_bin;
    logic [31:0]         bcd;
    logic [31:0]         bcd_adj;
    logic                vfo;
    logic [SET_W-1:0]    settle_cnt;
    logic [REF_W-1:0]    refresh_cnt;
    logic [5:0]          conv_cnt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic [BYTE_W-1:0]   dpos;
    logic [7:0]          cur_byte;
    logic                next_bit;
    logic                ptt_d;
    logic                pending_resend;

    logic ptt_rise, refresh_hit, resend_req, freq_new;
    logic settle_done, conv_done, baud_end, tx_done;

    assign ptt_rise    = ptt & ~ptt_d;
    assign refresh_hit = (REFRESH_CYCLES != 0) && (refresh_cnt == REF_MAX);
    assign resend_req  = pending_resend | ptt_rise | refresh_hit;
    assign freq_new    = (freq != last_sent);
    assign settle_done = (freq == freq_prev) && (settle_cnt == SET_MAX);
    assign conv_done   = (conv_cnt == 6'd63);
    assign baud_end    = (baud_cnt == BAUD_LAST);
    assign tx_done     = baud_end && (bit_idx == BIT_LAST) && (byte_idx == BYTE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (freq_new) begin
                    state_nx = ST_SETTLE;
                end else if (resend_req) begin
                    state_nx = ST_CONV;
                end
            end
            ST_SETTLE: if (settle_done) state_nx = ST_CONV;
            ST_CONV:   if (conv_done) state_nx = ST_TX;
            ST_TX:     if (tx_done) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Double-dabble correction step: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[i*4 +: 4] > 4'd4) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Byte being sent; digit bytes count down from the most significant position.
    always_comb begin
        dpos     = DPOS_TOP - byte_idx;
        cur_byte = 8'h3B;
        if (byte_idx == '0) begin
            cur_byte = 8'h46;
        end else if (byte_idx == BYTE_W'(1)) begin
            cur_byte = vfo ? 8'h42 : 8'h41;
        end else if (byte_idx != BYTE_LAST) begin
            if (dpos < BYTE_W'(8)) begin
                cur_byte = {4'h3, bcd[{dpos[2:0], 2'b00} +: 4]};
            end else begin
                cur_byte = 8'h30;
            end
        end
        next_bit = (bit_idx < BIT_W'(8)) ? cur_byte[bit_idx[2:0]] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_txd       <= 1'b1 ^ INV;
            sent           <= 1'b0;
            last_sent      <= '0;
            freq_prev      <= '0;
            freq_bin       <= '0;
            dd_bin         <= '0;
            bcd            <= '0;
            vfo            <= 1'b0;
            settle_cnt     <= '0;
            refresh_cnt    <= '0;
            conv_cnt       <= '0;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            byte_idx       <= '0;
            ptt_d          <= 1'b0;
            pending_resend <= 1'b0;
        end else begin
            sent  <= 1'b0;
            ptt_d <= ptt;

            // A ptt edge landing on the TX-start clock still earns a resend.
            if (state == ST_CONV && conv_done) pending_resend <= 1'b0;
            if (ptt_rise && state != ST_IDLE) pending_resend <= 1'b1;

            if (state == ST_IDLE && refresh_cnt != REF_MAX) begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (freq_new) begin
                        freq_prev  <= freq;
                        settle_cnt <= '0;
                    end else if (resend_req) begin
                        freq_bin <= freq;
                        vfo      <= vfo_sel;
                        dd_bin   <= (freq > FREQ_MAX) ? FREQ_MAX : freq;
                        bcd      <= '0;
                        conv_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (freq != freq_prev) begin
                        freq_prev  <= freq;
                        settle_cnt <= '0;
                    end else if (settle_done) begin
                        freq_bin <= freq;
                        vfo      <= vfo_sel;
                        dd_bin   <= (freq > FREQ_MAX) ? FREQ_MAX : freq;
                        bcd      <= '0;
                        conv_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_CONV: begin
                    conv_cnt <= conv_cnt + 6'd1;
                    if (!conv_cnt[0]) begin
                        bcd <= bcd_adj;
                    end else begin
                        bcd    <= {bcd[30:0], dd_bin[31]};
                        dd_bin <= {dd_bin[30:0], 1'b0};
                    end
                    if (conv_done) begin
                        uart_txd <= 1'b0 ^ INV;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_TX: begin
                    if (!baud_end) begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx != BIT_LAST) begin
                            bit_idx  <= bit_idx + BIT_W'(1);
                            uart_txd <= next_bit ^ INV;
                        end else if (byte_idx != BYTE_LAST) begin
                            byte_idx <= byte_idx + BYTE_W'(1);
                            bit_idx  <= '0;
                            uart_txd <= 1'b0 ^ INV;
                        end else begin
                            uart_txd    <= 1'b1 ^ INV;
                            sent        <= 1'b1;
                            last_sent   <= freq_bin;
                            refresh_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
